// File: rtl/apb_regfile.sv
// apb_regfile: APB slave register file with optional wait states,
// byte strobes, read-only (hardware-fed) registers and per-register write pulses.
//
// Ports:
//   pclk, preset               clock, asynchronous active-high reset
//   paddr, pwdata, pstrb       APB address (low ADDR_WIDTH bits decoded), write data, byte strobes
//   psel, penable, pwrite      APB control
//   pready, pslverr, prdata    APB response (pslverr/prdata meaningful only with pready)
//   regs_out                   contents of read-write registers, register i at slice i (RO slices read 0)
//   hw_in                      values presented by read-only registers
//   wr_pulse                   one-cycle pulse per register after each error-free write
//
// state  | meaning
// IDLE   | no transfer in progress, waiting for a setup phase
// ACCESS | access phase: counting down wait states, then completing on pready
module apb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [31:0]                    paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  output logic                           pready,
  output logic                           pslverr,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [31:0]           idx;
  logic [NUM_REGS-1:0]   hit;
  logic                  addr_err, ro_err, err;
  logic [DATA_WIDTH-1:0] rd_val;

  // Upper address bits are intentionally not decoded.
  logic unused_paddr;
  assign unused_paddr = ^paddr[31:ADDR_WIDTH];

  assign idx = 32'(paddr[ADDR_WIDTH-1:2]);

  // One-hot decode; an empty hit vector means misaligned or out-of-range.
  always_comb begin
    hit    = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (paddr[1:0] == 2'b00) && (idx == 32'(i));
      if (hit[i]) begin
        rd_val = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  assign addr_err = ~|hit;
  assign ro_err   = |(hit & RO_MASK);
  assign err      = addr_err | (pwrite & ro_err);

  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0) && psel && penable;
  assign pslverr = pready && err;
  assign prdata  = (pready && !pwrite && !err) ? rd_val : '0;
  assign wr_pulse = wr_pulse_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: nothing is written.
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            if (pwrite && !err) begin
              wr_pulse_d = hit;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (hit[i]) begin
                  for (int b = 0; b < NB; b++) begin
                    if (pstrb[b]) regs_d[i][b*8 +: 8] = pwdata[b*8 +: 8];
                  end
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read-only registers are fed from hw_in, so their storage slice is hidden.
  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

endmodule

// File: tb/tb_apb_regfile.sv
module tb_apb_regfile;

  localparam logic [7:0] RO0 = 8'h08;

  logic         pclk, preset;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   pstrb;
  logic         psel0, psel3, penable, pwrite;
  logic         pready0, pready3, pslverr0, pslverr3;
  logic [31:0]  prdata0, prdata3;
  logic [255:0] regs_out0, regs_out3, hw_in;
  logic [7:0]   wr_pulse0, wr_pulse3;

  int n_checks = 0;
  int n_errors = 0;

  apb_regfile #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(8), .WAIT_STATES(0), .RO_MASK(RO0)) dut0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel0), .penable(penable), .pwrite(pwrite), .pready(pready0), .pslverr(pslverr0),
    .prdata(prdata0), .regs_out(regs_out0), .hw_in(hw_in), .wr_pulse(wr_pulse0));

  apb_regfile #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(8), .WAIT_STATES(3), .RO_MASK(8'h00)) dut3 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel3), .penable(penable), .pwrite(pwrite), .pready(pready3), .pslverr(pslverr3),
    .prdata(prdata3), .regs_out(regs_out3), .hw_in(hw_in), .wr_pulse(wr_pulse3));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model for dut0
  logic [31:0] m_regs [8];

  function automatic logic [31:0] hw_val(int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic bit m_err(logic [31:0] a, bit wr);
    int i;
    i = int'(a[7:2]);
    if (a[1:0] != 2'b00) return 1'b1;
    if (i >= 8) return 1'b1;
    if (wr && RO0[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [255:0] m_regs_out();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = RO0[i] ? 32'h0 : m_regs[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete APB transfer on the selected DUT (w3=1 selects the wait-state DUT).
  task automatic xfer(input bit w3, input logic [31:0] addr, input bit wr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int waits, output logic [7:0] pulse1, output logic [7:0] pulse2);
    @(negedge pclk);
    if (w3) psel3 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    #1;
    while (!(w3 ? pready3 : pready0) && waits < 20) begin
      @(negedge pclk);
      #1;
      waits++;
    end
    chk("xfer_timeout", 256'(waits >= 20), 256'(0));
    rdata = w3 ? prdata3 : prdata0;
    err   = w3 ? pslverr3 : pslverr0;
    @(posedge pclk);
    #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    pulse1 = w3 ? wr_pulse3 : wr_pulse0;
    @(posedge pclk);
    #1;
    pulse2 = w3 ? wr_pulse3 : wr_pulse0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
    logic [7:0]  exp_pulse;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] rd, a, d;
    logic        e, w;
    logic [3:0]  s;
    int          wt, idx;
    logic [7:0]  p1, p2;

    vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 8'h02};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0,        1'b0, 8'h04};
    vecs[3]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 8'h04};
    vecs[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 32'h06, 32'h0,        4'h0, 32'h0,        1'b1, 8'h00};
    vecs[6]  = '{1'b1, 32'h06, 32'h99999999, 4'hF, 32'h0,        1'b1, 8'h00};
    vecs[7]  = '{1'b0, 32'h20, 32'h0,        4'h0, 32'h0,        1'b1, 8'h00};
    vecs[8]  = '{1'b1, 32'h20, 32'h77777777, 4'hF, 32'h0,        1'b1, 8'h00};
    vecs[9]  = '{1'b1, 32'h0C, 32'h55555555, 4'hF, 32'h0,        1'b1, 8'h00};
    vecs[10] = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'hC0DE0003, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 8'h00};

    for (int i = 0; i < 8; i++) hw_in[i*32 +: 32] = hw_val(i);
    preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    m_reset();
    #1;
    chk("rst_pready", 256'(pready0), 256'(0));
    chk("rst_prdata", 256'(prdata0), 256'(0));
    chk("rst_regs_out", regs_out0, 256'(0));
    chk("rst_wr_pulse", 256'(wr_pulse0), 256'(0));
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;

    // Directed vectors on the zero-wait DUT
    for (int k = 0; k < 13; k++) begin
      xfer(1'b0, vecs[k].addr, vecs[k].wr, vecs[k].data, vecs[k].strb, rd, e, wt, p1, p2);
      chk($sformatf("vec%0d_waits", k), 256'(wt), 256'(0));
      chk($sformatf("vec%0d_err", k), 256'(e), 256'(vecs[k].exp_err));
      if (!vecs[k].wr) chk($sformatf("vec%0d_rdata", k), 256'(rd), 256'(vecs[k].exp_rd));
      chk($sformatf("vec%0d_pulse", k), 256'(p1), 256'(vecs[k].exp_pulse));
      chk($sformatf("vec%0d_pulse_end", k), 256'(p2), 256'(0));
      if (vecs[k].wr && !m_err(vecs[k].addr, 1'b1)) begin
        idx = int'(vecs[k].addr[7:2]);
        for (int b = 0; b < 4; b++)
          if (vecs[k].strb[b]) m_regs[idx][b*8 +: 8] = vecs[k].data[b*8 +: 8];
      end
      chk($sformatf("vec%0d_regs_out", k), regs_out0, m_regs_out());
    end

    // Randomized traffic against the model
    for (int k = 0; k < 150; k++) begin
      a = 32'($urandom_range(0, 35)) | ($urandom & 32'hFFFF_FF00);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      xfer(1'b0, a, w, d, s, rd, e, wt, p1, p2);
      idx = int'(a[7:2]);
      chk("rnd_err", 256'(e), 256'(m_err(a, w)));
      if (!w) begin
        if (m_err(a, 1'b0)) chk("rnd_rdata_err", 256'(rd), 256'(0));
        else chk("rnd_rdata", 256'(rd), 256'(RO0[idx] ? hw_val(idx) : m_regs[idx]));
      end
      if (w && !m_err(a, 1'b1)) begin
        for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
        chk("rnd_pulse", 256'(p1), 256'(8'h01 << idx));
      end else begin
        chk("rnd_pulse", 256'(p1), 256'(0));
      end
      chk("rnd_pulse_end", 256'(p2), 256'(0));
      chk("rnd_regs_out", regs_out0, m_regs_out());
    end

    // Wait states: three low access cycles before pready
    xfer(1'b1, 32'h00, 1'b0, 32'h0, 4'h0, rd, e, wt, p1, p2);
    chk("ws_read_waits", 256'(wt), 256'(3));
    chk("ws_read_rdata", 256'(rd), 256'(0));
    xfer(1'b1, 32'h14, 1'b1, 32'hCAFEF00D, 4'hF, rd, e, wt, p1, p2);
    chk("ws_write_waits", 256'(wt), 256'(3));
    chk("ws_write_pulse", 256'(p1), 256'(8'h20));
    chk("ws_write_err", 256'(e), 256'(0));

    // Abort: psel drops mid-wait
    @(negedge pclk);
    psel3 = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'h0BADBEEF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    #1;
    chk("abort_pready", 256'(pready3), 256'(0));
    psel3 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_pulse", 256'(wr_pulse3), 256'(0));
    @(posedge pclk); #1;
    chk("abort_pulse2", 256'(wr_pulse3), 256'(0));
    xfer(1'b1, 32'h14, 1'b0, 32'h0, 4'h0, rd, e, wt, p1, p2);
    chk("abort_rdata", 256'(rd), 256'(32'hCAFEF00D));

    // Reset during an access phase
    @(negedge pclk);
    psel0 = 1'b1; penable = 1'b0; paddr = 32'h04; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    chk("rstmid_pready_before", 256'(pready0), 256'(1));
    preset = 1'b1;
    #1;
    chk("rstmid_pready", 256'(pready0), 256'(0));
    chk("rstmid_pslverr", 256'(pslverr0), 256'(0));
    chk("rstmid_prdata", 256'(prdata0), 256'(0));
    chk("rstmid_regs_out0", regs_out0, 256'(0));
    chk("rstmid_regs_out3", regs_out3, 256'(0));
    chk("rstmid_wr_pulse", 256'(wr_pulse0), 256'(0));
    @(posedge pclk);
    @(negedge pclk);
    psel0 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    m_reset();
    xfer(1'b0, 32'h04, 1'b0, 32'h0, 4'h0, rd, e, wt, p1, p2);
    chk("rstmid_no_write", 256'(rd), 256'(0));
    chk("rstmid_regs_after", regs_out0, m_regs_out());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
